// File: rtl/d_e_md_reg.sv
// D/E pipeline register for the multiply/divide path. It carries a scoreboard that
// mirrors the HI/LO unit's busy countdown and holds md-class ops in D while that unit is busy.
module d_e_md_reg #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_num1,
  input  logic [31:0] d_num2,
  input  logic [10:0] d_hiloOp,
  input  logic        stall_ext,
  output logic [31:0] e_pc,
  output logic [31:0] e_instr,
  output logic [31:0] e_num1,
  output logic [31:0] e_num2,
  output logic [10:0] e_hiloOp,
  output logic        md_stall,
  output logic        md_busy,
  output logic [1:0]  md_kind
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } kind_t;

  kind_t      state;
  logic [3:0] cnt;
  logic       md_class;
  logic       e_start;
  logic       stall_all;

  // A D-stage md op waits while a start sits in E or more than one busy cycle remains;
  // with cnt == 1 it may advance, since the unit frees at the edge it enters E.
  assign md_class  = |d_hiloOp[7:0];
  assign e_start   = |e_hiloOp[3:0];
  assign md_stall  = md_class & (e_start | (cnt > 4'd1));
  assign stall_all = md_stall | stall_ext;
  assign md_busy   = (cnt != 4'd0);
  assign md_kind   = state;

  always_ff @(posedge clk) begin
    if (reset || stall_all) begin
      e_pc     <= '0;
      e_instr  <= '0;
      e_num1   <= '0;
      e_num2   <= '0;
      e_hiloOp <= '0;
    end else begin
      e_pc     <= d_pc;
      e_instr  <= d_instr;
      e_num1   <= d_num1;
      e_num2   <= d_num2;
      e_hiloOp <= d_hiloOp;
    end
  end

  // Start ops are only honoured when idle; one arriving mid-countdown is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 4'd0;
      state <= IDLE;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        state <= IDLE;
      end
    end else if (e_hiloOp[0] || e_hiloOp[1]) begin
      cnt   <= 4'(MULT_CYCLES);
      state <= MUL;
    end else if (e_hiloOp[2] || e_hiloOp[3]) begin
      cnt   <= 4'(DIV_CYCLES);
      state <= DIV;
    end
  end

endmodule

// File: tb/tb_d_e_md_reg.sv
// Directed testbench for d_e_md_reg: a per-cycle vector table for issue, latency and
// passthrough behaviour, plus a hand-written reset-during-divide sequence.
module tb_d_e_md_reg;

  logic        clk;
  logic        reset;
  logic [31:0] d_pc, d_instr, d_num1, d_num2;
  logic [10:0] d_hiloOp;
  logic        stall_ext;
  logic [31:0] e_pc, e_instr, e_num1, e_num2;
  logic [10:0] e_hiloOp;
  logic        md_stall, md_busy;
  logic [1:0]  md_kind;

  int tests_run = 0;
  int tests_failed = 0;

  d_e_md_reg #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .d_pc(d_pc), .d_instr(d_instr), .d_num1(d_num1), .d_num2(d_num2),
    .d_hiloOp(d_hiloOp), .stall_ext(stall_ext),
    .e_pc(e_pc), .e_instr(e_instr), .e_num1(e_num1), .e_num2(e_num2),
    .e_hiloOp(e_hiloOp), .md_stall(md_stall), .md_busy(md_busy), .md_kind(md_kind)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One record per cycle: D-stage inputs, then the outputs expected in that cycle.
  typedef struct {
    logic        rst;
    logic [10:0] op;
    logic [31:0] num1;
    logic        sx;
    logic        x_stall;
    logic        x_busy;
    logic [1:0]  x_kind;
    logic [10:0] x_op;
    logic [31:0] x_num1;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic [10:0] op, logic [31:0] num1, logic sx,
                              logic x_stall, logic x_busy, logic [1:0] x_kind,
                              logic [10:0] x_op, logic [31:0] x_num1);
    vec_t v;
    v.rst = rst; v.op = op; v.num1 = num1; v.sx = sx;
    v.x_stall = x_stall; v.x_busy = x_busy; v.x_kind = x_kind;
    v.x_op = x_op; v.x_num1 = x_num1;
    vecs.push_back(v);
  endfunction

  // Other operand fields are derived from num1 so one column identifies the instruction.
  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    d_hiloOp  = v.op;
    d_num1    = v.num1;
    d_num2    = v.num1 - 32'd10;
    d_pc      = v.num1 + 32'h1000;
    d_instr   = v.num1 ^ 32'hABCD0000;
    stall_ext = v.sx;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVector(input vec_t v, input string tag);
    logic [31:0] x_pc, x_instr, x_num2;
    x_pc    = (v.x_num1 == 0) ? 32'd0 : v.x_num1 + 32'h1000;
    x_instr = (v.x_num1 == 0) ? 32'd0 : v.x_num1 ^ 32'hABCD0000;
    x_num2  = (v.x_num1 == 0) ? 32'd0 : v.x_num1 - 32'd10;
    checkOutput({tag, " md_stall"}, {31'd0, md_stall}, {31'd0, v.x_stall});
    checkOutput({tag, " md_busy"},  {31'd0, md_busy},  {31'd0, v.x_busy});
    checkOutput({tag, " md_kind"},  {30'd0, md_kind},  {30'd0, v.x_kind});
    checkOutput({tag, " e_hiloOp"}, {21'd0, e_hiloOp}, {21'd0, v.x_op});
    checkOutput({tag, " e_num1"},   e_num1,  v.x_num1);
    checkOutput({tag, " e_num2"},   e_num2,  x_num2);
    checkOutput({tag, " e_pc"},     e_pc,    x_pc);
    checkOutput({tag, " e_instr"},  e_instr, x_instr);
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkVector(v, tag);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; d_hiloOp = 11'h001; d_num1 = 32'd7; d_num2 = -32'd3;
    d_pc = 32'h1007; d_instr = 32'hABCD0007; stall_ext = 1'b0;

    // Reset held with mult in D, then mult (7, -3) followed by a waiting mflo.
    add(1, 11'h001, 32'h7,  0,  0, 0, 0, 11'h000, 32'h0);
    add(1, 11'h001, 32'h7,  0,  0, 0, 0, 11'h000, 32'h0);
    add(0, 11'h001, 32'h7,  0,  0, 0, 0, 11'h000, 32'h0);
    add(0, 11'h080, 32'h11, 0,  1, 0, 0, 11'h001, 32'h7);
    for (int i = 0; i < 4; i++) add(0, 11'h080, 32'h11, 0,  1, 1, 1, 11'h000, 32'h0);
    add(0, 11'h080, 32'h11, 0,  0, 1, 1, 11'h000, 32'h0);
    add(0, 11'h000, 32'h22, 0,  0, 0, 0, 11'h080, 32'h11);
    // divu then mfhi: ten stalled cycles, kind 2.
    add(0, 11'h008, 32'h64, 0,  0, 0, 0, 11'h000, 32'h22);
    add(0, 11'h040, 32'h33, 0,  1, 0, 0, 11'h008, 32'h64);
    for (int i = 0; i < 9; i++) add(0, 11'h040, 32'h33, 0,  1, 1, 2, 11'h000, 32'h0);
    add(0, 11'h040, 32'h33, 0,  0, 1, 2, 11'h000, 32'h0);
    // mult then addu passthrough, then stall_ext bubbles during the countdown.
    add(0, 11'h001, 32'h5,  0,  0, 0, 0, 11'h040, 32'h33);
    add(0, 11'h000, 32'h44, 0,  0, 0, 0, 11'h001, 32'h5);
    add(0, 11'h000, 32'h55, 1,  0, 1, 1, 11'h000, 32'h44);
    add(0, 11'h000, 32'h55, 1,  0, 1, 1, 11'h000, 32'h0);
    add(0, 11'h000, 32'h55, 1,  0, 1, 1, 11'h000, 32'h0);
    add(0, 11'h000, 32'h55, 0,  0, 1, 1, 11'h000, 32'h0);
    // Next mult advances at cnt == 1, then a back-to-back multu waits five cycles.
    add(0, 11'h001, 32'h9,  0,  0, 1, 1, 11'h000, 32'h55);
    add(0, 11'h002, 32'h66, 0,  1, 0, 0, 11'h001, 32'h9);
    for (int i = 0; i < 4; i++) add(0, 11'h002, 32'h66, 0,  1, 1, 1, 11'h000, 32'h0);
    add(0, 11'h002, 32'h66, 0,  0, 1, 1, 11'h000, 32'h0);
    add(0, 11'h000, 32'h77, 0,  0, 0, 0, 11'h002, 32'h66);

    foreach (vecs[i]) step(vecs[i], $sformatf("row%0d", i));

    // Reset in the middle of a div countdown releases a waiting mfhi.
    v = vecs[0];
    v.rst = 1; v.op = 11'h000; v.num1 = 32'h1;
    v.x_stall = 0; v.x_busy = 1; v.x_kind = 1; v.x_op = 11'h000; v.x_num1 = 32'h77;
    step(v, "rst_mid a");
    v.rst = 0; v.op = 11'h004; v.num1 = 32'h2;
    v.x_busy = 0; v.x_kind = 0; v.x_num1 = 32'h0;
    step(v, "rst_mid div");
    v.op = 11'h040; v.num1 = 32'h3;
    v.x_stall = 1; v.x_op = 11'h004; v.x_num1 = 32'h2;
    step(v, "rst_mid mfhi");
    v.x_busy = 1; v.x_kind = 2; v.x_op = 11'h000; v.x_num1 = 32'h0;
    for (int i = 0; i < 4; i++) step(v, $sformatf("rst_mid cnt%0d", 10 - i));
    v.rst = 1;
    step(v, "rst_mid cnt6");
    v.rst = 0; v.x_stall = 0; v.x_busy = 0; v.x_kind = 0;
    step(v, "rst_mid after");
    v.op = 11'h000; v.num1 = 32'h4; v.x_op = 11'h040; v.x_num1 = 32'h3;
    step(v, "rst_mid released");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/d_e_md_reg.md
# d_e_md_reg

D/E pipeline register for the multiply/divide path, with an internal scoreboard that tracks the HI/LO unit's occupancy. It latches the D-stage operands and HI/LO op for the E stage. It decides, in the same cycle an instruction is decoded, whether an md-class instruction may enter E, and inserts a bubble when it may not. It sits directly upstream of the E-stage HI/LO unit and mirrors that unit's busy countdown exactly, so the HI/LO unit never sees an op while busy.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issue (legal 2..15)
- DIV_CYCLES, 10, busy cycles after a div/divu issue (legal 2..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- d_pc  in  32  D-stage PC
- d_instr  in  32  D-stage instruction word
- d_num1  in  32  rs operand (forwarded)
- d_num2  in  32  rt operand (forwarded)
- d_hiloOp  in  11  one-hot: [0] mult, [1] multu, [2] div, [3] divu, [4] mthi, [5] mtlo, [6] mfhi, [7] mflo, [10:8] must be 0; all-zero = not md-class
- stall_ext  in  1  stall request from the data-hazard unit
- e_pc, e_instr, e_num1, e_num2  out  32 each  E-stage registered copies
- e_hiloOp  out  11  E-stage registered op, feeds the HI/LO unit
- md_stall  out  1  freeze F/D because of the HI/LO unit (combinational)
- md_busy  out  1  scoreboard counter nonzero
- md_kind  out  2  0 idle, 1 multiply in flight, 2 divide in flight

## Operation
- md_class = |d_hiloOp[7:0]; e_start = |e_hiloOp[3:0].
- md_stall = md_class & (e_start | cnt > 1).
- stall_all = md_stall | stall_ext.
- Pipeline register on each clk edge:
  - reset: all e_* outputs are 0.
  - stall_all: bubble. All e_* outputs are 0, so the HI/LO unit sees op 0.
  - otherwise: e_* load the d_* values.
- Scoreboard counter cnt (4 bits), kind state machine (IDLE/MUL/DIV):
  - reset: cnt = 0, IDLE.
  - cnt == 0 and e_hiloOp[0] or [1]: cnt <= MULT_CYCLES, state MUL.
  - cnt == 0 and e_hiloOp[2] or [3]: cnt <= DIV_CYCLES, state DIV.
  - cnt > 0: cnt <= cnt-1; state returns to IDLE when cnt goes 1 -> 0.
  - e_start is never registered while cnt > 0; md_stall guarantees this. A start op in E with cnt > 0 is ignored and cnt keeps decrementing.
- md_busy = cnt != 0. md_kind encodes the state.
- mthi/mtlo/mfhi/mflo start no countdown. They are still stalled behind a busy unit.
- Non-md instructions are never stalled by this block; md_stall = 0 for them.
- The scoreboard counts regardless of stall_ext.

## Timing
- The HI/LO unit sets its counter at the edge closing the issue cycle and stays busy N cycles. cnt tracks it cycle-for-cycle.
- Example: mult in E in cycle t. cnt = 5,4,3,2,1 in cycles t+1..t+5. md_stall is asserted for a D md-op in cycles t..t+4. The op enters E in cycle t+6, when the HI/LO counter is 0.
- With cnt == 1 no stall is raised: the op enters E exactly as the unit frees.
- Back-to-back mult/mult: the second mult waits N cycles, issuing in E at t+N+1.
- md_stall and a held D instruction: D holds its value. The E-stage bubble repeats each stalled cycle.
- Reset mid-countdown: cnt and state clear at that edge. e_* go to 0. md_stall deasserts in the following cycle unless e_start is asserted.
- All outputs are 0 after reset.

## Test plan
- Reset: hold reset 2 cycles with d_hiloOp = 0x001 -> all e_* = 0, md_busy = 0, md_kind = 0, md_stall = 0 after release until the op is in E.
- mult issue: d_hiloOp = 0x001, num1 = 7, num2 = -3, then mflo (0x080) in D -> md_stall high for 5 cycles (E start + cnt 5..2), mflo reaches E when cnt = 0, md_kind = 1 during the countdown.
- div latency: divu (0x008) then mfhi (0x040) -> md_stall high for 10 cycles, md_kind = 2, md_busy falls after 10 cycles.
- Non-md passthrough: mult then addu (op 0) in D -> md_stall = 0, addu latched immediately with its d_num1/d_num2 values.
- stall_ext interplay: stall_ext = 1 for 3 cycles during a mult countdown -> bubbles in E, cnt still decrements 5 -> 2, no double issue.
- Reset mid-operation: assert reset at cnt = 6 of a div -> cnt = 0, md_kind = 0 next cycle, a waiting mfhi is released.
